// File: rtl/formula_n_pipe_aware_fsm.sv
// formula_n_pipe_aware_fsm
// Computes res = sum over k of isqrt(arg k) using an external pipelined isqrt
// unit of unknown latency. Arguments are issued one per cycle; completion is
// detected purely by counting returned results, so the latency never appears
// in this block.
module formula_n_pipe_aware_fsm #(
    parameter int N_ARGS = 3,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arg_vld,
    input  logic [N_ARGS*W-1:0] args,
    output logic                arg_rdy,
    output logic                res_vld,
    output logic [W-1:0]        res,
    output logic                isqrt_x_vld,
    output logic [W-1:0]        isqrt_x,
    input  logic                isqrt_y_vld,
    input  logic [W/2-1:0]      isqrt_y
);

    localparam int              CNT_W    = $clog2(N_ARGS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ARGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_ARGS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     res_q, res_d;
    logic             res_vld_q, res_vld_d;

    // Latched argument bank: pure data, only loaded on acceptance.
    logic [W-1:0]     args_q [N_ARGS];
    logic [W-1:0]     args_d [N_ARGS];
    logic             load_args;

    logic             rsp_take;
    logic [W-1:0]     y_ext;

    // Next-state, counter, accumulator and result computation.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_vld_d   = 1'b0;
        load_args   = 1'b0;
        rsp_take    = 1'b0;
        y_ext       = {{(W - W/2){1'b0}}, isqrt_y};

        case (state_q)
            IDLE: begin
                if (arg_vld) begin
                    load_args   = 1'b1;
                    acc_d       = '0;
                    issue_cnt_d = '0;
                    rsp_cnt_d   = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + CNT_ONE;
                if (issue_cnt_q == LAST_IDX) begin
                    state_d = COLLECT;
                end
                // Short latencies return results while still issuing.
                rsp_take = isqrt_y_vld;
            end
            COLLECT: begin
                rsp_take = isqrt_y_vld;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Responses beyond the expected count are dropped.
        if (rsp_take && (rsp_cnt_q < CNT_MAX)) begin
            acc_d     = acc_q + y_ext;
            rsp_cnt_d = rsp_cnt_q + CNT_ONE;
            if (rsp_cnt_q == LAST_IDX) begin
                res_d     = acc_q + y_ext;
                res_vld_d = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    // Argument bank next value: capture the bus on acceptance, else hold.
    always_comb begin
        for (int k = 0; k < N_ARGS; k++) begin
            args_d[k] = load_args ? args[k*W +: W] : args_q[k];
        end
    end

    // Control and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_vld_q   <= res_vld_d;
        end
    end

    // Argument bank storage; contents are don't-care until first acceptance.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_ARGS; k++) begin
            args_q[k] <= args_d[k];
        end
    end

    // Output decode: operand mux is forced to zero outside ISSUE.
    always_comb begin
        arg_rdy     = (state_q == IDLE);
        isqrt_x_vld = (state_q == ISSUE);
        isqrt_x     = '0;
        if (state_q == ISSUE) begin
            for (int k = 0; k < N_ARGS; k++) begin
                if (issue_cnt_q == CNT_W'(k)) begin
                    isqrt_x = args_q[k];
                end
            end
        end
        res     = res_q;
        res_vld = res_vld_q;
    end

endmodule

// File: tb/tb_formula_n_pipe_aware_fsm.sv
// Testbench for formula_n_pipe_aware_fsm: two instances (N_ARGS=3 and 1), each
// with a behavioural external isqrt pipeline of programmable latency and a
// scoreboard monitor.
`timescale 1ns/1ps
module tb_formula_n_pipe_aware_fsm;

    localparam int W  = 32;
    localparam int HW = W / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           arg_vld_v [2];
    logic [3*W-1:0] args_bus  [2];
    int             lat       [2];
    logic [1:0]     rdy_v;

    int checks = 0;
    int errors = 0;

    // Reference integer square root by binary search.
    function automatic longint unsigned isqrt_ref(input longint unsigned v);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int NA = (g == 0) ? 3 : 1;

        logic          arg_rdy, res_vld, x_vld;
        logic [W-1:0]  res, x;
        logic          y_vld = 1'b0;
        logic [HW-1:0] y = '0;

        int            cyc = 0;
        int            busy_until = 0;
        int            pend = 0;
        logic [W-1:0]  res_last = '0;
        bit            model_rdy, exp_x, exp_r;
        logic [W-1:0]  sum;

        int            xcyc [$];
        logic [W-1:0]  xval [$];
        int            scyc [$];
        logic [W-1:0]  ssum [$];
        int            pdue [$];
        logic [HW-1:0] pval [$];

        formula_n_pipe_aware_fsm #(.N_ARGS(NA), .W(W)) dut (
            .clk         (clk),
            .rst         (rst),
            .arg_vld     (arg_vld_v[g]),
            .args        (args_bus[g][NA*W-1:0]),
            .arg_rdy     (arg_rdy),
            .res_vld     (res_vld),
            .res         (res),
            .isqrt_x_vld (x_vld),
            .isqrt_x     (x),
            .isqrt_y_vld (y_vld),
            .isqrt_y     (y)
        );

        assign rdy_v[g] = arg_rdy;

        // External isqrt model plus scoreboard monitor, evaluated mid-cycle.
        always @(negedge clk) begin
            cyc++;
            // isqrt pipeline: respond L cycles after issue; junk pulses while idle
            if (pdue.size() > 0 && pdue[0] == cyc) begin
                y_vld = 1'b1;
                y     = pval.pop_front();
                void'(pdue.pop_front());
            end else if (cyc >= busy_until && $urandom_range(3) == 0) begin
                y_vld = 1'b1;
                y     = HW'($urandom);
            end else begin
                y_vld = 1'b0;
                y     = HW'($urandom);
            end

            if (rst) begin
                xcyc.delete(); xval.delete(); scyc.delete(); ssum.delete();
                busy_until = 0;
                res_last   = '0;
                chk("rst_res_vld", 64'(res_vld), 64'd0);
                chk("rst_x_vld", 64'(x_vld), 64'd0);
                chk("rst_x", 64'(x), 64'd0);
                chk("rst_res", 64'(res), 64'd0);
                chk("rst_arg_rdy", 64'(arg_rdy), 64'd1);
            end else begin
                model_rdy = (cyc >= busy_until);
                chk("arg_rdy", 64'(arg_rdy), 64'(model_rdy));
                exp_x = (xcyc.size() > 0 && xcyc[0] == cyc);
                chk("isqrt_x_vld", 64'(x_vld), 64'(exp_x));
                if (exp_x) begin
                    void'(xcyc.pop_front());
                    chk("isqrt_x", 64'(x), 64'(xval.pop_front()));
                end else begin
                    chk("isqrt_x_idle", 64'(x), 64'd0);
                end
                exp_r = (scyc.size() > 0 && scyc[0] == cyc);
                chk("res_vld", 64'(res_vld), 64'(exp_r));
                if (exp_r) begin
                    void'(scyc.pop_front());
                    res_last = ssum.pop_front();
                end
                chk("res", 64'(res), 64'(res_last));
                if (arg_vld_v[g] === 1'b1 && model_rdy) begin
                    sum = '0;
                    for (int k = 0; k < NA; k++) begin
                        xcyc.push_back(cyc + 1 + k);
                        xval.push_back(args_bus[g][k*W +: W]);
                        sum = sum + W'(isqrt_ref(64'(args_bus[g][k*W +: W])));
                    end
                    busy_until = cyc + NA + lat[g] + 1;
                    scyc.push_back(busy_until);
                    ssum.push_back(sum);
                end
            end

            if (x_vld === 1'b1) begin
                pdue.push_back(cyc + lat[g]);
                pval.push_back(HW'(isqrt_ref(64'(x))));
            end
            pend = scyc.size() + pdue.size();
        end
    end

    function automatic logic [W-1:0] rv();
        case ($urandom_range(3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // Present an argument set and hold it until accepted (bounded).
    task automatic send(input int i, input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] a2);
        int budget;
        bit r;
        budget = 0;
        arg_vld_v[i] = 1'b1;
        args_bus[i]  = {a2, a1, a0};
        do begin
            r = rdy_v[i];
            @(posedge clk); #1;
            budget++;
        end while (!r && budget < 200);
        if (!r) begin
            checks++; errors++;
            $display("FAIL send_timeout: inst %0d arg_rdy 0 for %0d cycles, required 1", i, budget);
        end
    endtask

    task automatic idle(input int i);
        arg_vld_v[i] = 1'b0;
        args_bus[i]  = {W'($urandom), W'($urandom), W'($urandom)};
    endtask

    // Wait until all expected results and in-flight responses are retired.
    task automatic drain(input int i);
        int budget, p;
        budget = 0;
        do begin
            @(posedge clk); #1;
            p = (i == 0) ? g_u[0].pend : g_u[1].pend;
            budget++;
        end while ((p != 0 || rdy_v[i] !== 1'b1) && budget < 300);
        if (p != 0 || rdy_v[i] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL drain_timeout: inst %0d pending %0d, required 0", i, p);
        end
    endtask

    initial begin
        arg_vld_v[0] = 1'b0; arg_vld_v[1] = 1'b0;
        args_bus[0]  = '0;   args_bus[1]  = '0;
        lat[0] = 4; lat[1] = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single transaction, L=4: expect 2+3+4 = 9
        send(0, 32'd4, 32'd9, 32'd16); idle(0); drain(0);
        // back-to-back with arg_vld held high: 9 then 3
        send(0, 32'd4, 32'd9, 32'd16); send(0, 32'd1, 32'd1, 32'd1); idle(0); drain(0);
        // maximum operands: 3*65535
        send(0, '1, '1, '1); idle(0); drain(0);
        // arg_vld pulse during ISSUE is ignored
        send(0, 32'd0, 32'd1, 32'd4);
        arg_vld_v[0] = 1'b1; args_bus[0] = {32'd100, 32'd100, 32'd100};
        @(posedge clk); #1;
        idle(0); drain(0);
        // L=1: responses overlap ISSUE
        lat[0] = 1;
        send(0, 32'd49, 32'd64, 32'd81); idle(0); drain(0);

        // reset during COLLECT, released before responses return
        lat[0] = 4;
        send(0, 32'd4, 32'd9, 32'd16); idle(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_res_vld", 64'(g_u[0].res_vld), 64'd0);
        chk("async_rst_x_vld", 64'(g_u[0].x_vld), 64'd0);
        chk("async_rst_x", 64'(g_u[0].x), 64'd0);
        chk("async_rst_res", 64'(g_u[0].res), 64'd0);
        chk("async_rst_arg_rdy", 64'(g_u[0].arg_rdy), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        drain(0);
        send(0, 32'd25, 32'd36, 32'd49); idle(0); drain(0);

        // randomized bursts with random latency
        for (int it = 0; it < 25; it++) begin
            lat[0] = $urandom_range(1, 6);
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                send(0, rv(), rv(), rv());
            end
            idle(0);
            if ($urandom_range(1) == 1) begin
                arg_vld_v[0] = 1'b1;
                @(posedge clk); #1;
                idle(0);
            end
            drain(0);
        end

        // single-argument instance
        lat[1] = 1;
        send(1, 32'd144, '0, '0); idle(1); drain(1);
        for (int it = 0; it < 8; it++) begin
            lat[1] = $urandom_range(1, 5);
            send(1, rv(), '0, '0);
            if ($urandom_range(1) == 1) send(1, rv(), '0, '0);
            idle(1); drain(1);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/formula_n_pipe_aware_fsm.md
FORMULA_N_PIPE_AWARE_FSM -- requirements
Module: formula_n_pipe_aware_fsm

Interface
REQ-001 Parameter N_ARGS, default 3, number of arguments per transaction; SHALL be >= 1.
REQ-002 Parameter W, default 32, argument and result width; SHALL be even.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 arg_vld  input  1  argument set valid; accepted only when arg_rdy=1.
REQ-006 args  input  N_ARGS*W  argument k at bits [k*W +: W], k=0..N_ARGS-1.
REQ-007 arg_rdy  output  1  block idle and able to accept arguments.
REQ-008 res_vld  output  1  one-cycle pulse, res valid.
REQ-009 res  output  W  sum of isqrt(arg k) over all k.
REQ-010 isqrt_x_vld  output  1  valid to the external pipelined isqrt.
REQ-011 isqrt_x  output  W  operand to isqrt.
REQ-012 isqrt_y_vld  input  1  isqrt result valid.
REQ-013 isqrt_y  input  W/2  isqrt result.

Function
REQ-014 The block SHALL NOT instantiate isqrt and SHALL NOT depend on its latency L; completion is detected by counting isqrt_y_vld pulses.
REQ-015 States SHALL be IDLE, ISSUE, COLLECT.
REQ-016 IDLE: arg_rdy=1; on arg_vld, args latched into an internal register bank, accumulator and both counters cleared, go to ISSUE.
REQ-017 ISSUE: isqrt_x_vld=1, isqrt_x = latched argument[issue_cnt], one argument per cycle in order k=0..N_ARGS-1; after the issue of k=N_ARGS-1, go to COLLECT.
REQ-018 Outside ISSUE, isqrt_x_vld SHALL be 0 and isqrt_x SHALL be 0.
REQ-019 In ISSUE and COLLECT, each isqrt_y_vld SHALL add zero-extended isqrt_y to the W-bit accumulator (modulo 2^W) and increment rsp_cnt; results arriving during ISSUE (small L) SHALL be counted.
REQ-020 When the accepted response makes rsp_cnt reach N_ARGS, the next cycle SHALL show res = final sum and res_vld=1 for exactly one cycle, with state IDLE in that same cycle.
REQ-021 res SHALL hold its last value until the next completion.
REQ-022 isqrt_y_vld in IDLE, or beyond N_ARGS responses, SHALL be ignored.
REQ-023 arg_vld while arg_rdy=0 SHALL be ignored; args changes after acceptance SHALL NOT affect the transaction.
REQ-024 Throughput: a new transaction SHALL be acceptable in the res_vld cycle, giving one transaction per N_ARGS+L+1 cycles back-to-back.
REQ-025 Counters SHALL be sized $clog2(N_ARGS+1) bits; N_ARGS=1 SHALL skip directly from one ISSUE cycle to COLLECT.

Reset
REQ-026 rst=1 SHALL immediately (without a clock edge) force state IDLE, counters 0, accumulator 0, res 0, res_vld 0, isqrt_x_vld 0, isqrt_x 0; arg_rdy=1 during and after reset.
REQ-027 Reset mid-transaction SHALL abort it with no res_vld; in-flight isqrt responses arriving after reset SHALL be ignored (state IDLE).

Verification
REQ-028 N_ARGS=3, W=32, L=4: args {4,9,16} -> isqrt_x 4,9,16 on 3 consecutive cycles after accept; res=9, res_vld pulse at accept+N_ARGS+L+1.
REQ-029 Back-to-back: {4,9,16} then {1,1,1} with arg_vld held high -> res 9 then 3, second accept in first res_vld cycle, no lost or merged pulses.
REQ-030 Max operands {0xFFFFFFFF x3} -> res = 196605 (3*65535).
REQ-031 arg_vld pulsed with {100,100,100} during ISSUE of {0,1,4} -> ignored; res=3, isqrt_x never 100.
REQ-032 Reset asserted during COLLECT of {4,9,16}, released before responses return -> no res_vld, outputs zero, next transaction {25,36,49} gives res=18.
REQ-033 N_ARGS=1, L=1: args {144} -> res=12; also a L=1 run for N_ARGS=3 with responses overlapping ISSUE gives correct sum.
